// File: rtl/snn_seq_ctrl_if.sv
// Signal bundle between the SNN sequencer and its UART, input-unit RAM and
// inference core. The master modport is the sequencer side.
interface snn_seq_ctrl_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic       ram_d;
  logic       core_start;
  logic       core_done;
  logic [3:0] core_digit;
  logic       tx_rdy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] digit_out;
  logic       overrun;

  modport master (
    input  rx_rdy, rx_data, core_done, core_digit, tx_rdy,
    output ram_we, ram_addr, ram_d, core_start, tx_start, tx_data,
           digit_out, overrun
  );

  modport slave (
    output rx_rdy, rx_data, core_done, core_digit, tx_rdy,
    input  ram_we, ram_addr, ram_d, core_start, tx_start, tx_data,
           digit_out, overrun
  );
endinterface

// File: rtl/snn_seq_ctrl.sv
// Sequencer: unpacks 98 UART bytes into 784 pixel writes, starts the
// inference core, then sends the resulting digit back as one ASCII byte.
module snn_seq_ctrl (
  input logic            clk,
  input logic            rst,
  snn_seq_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    START,
    WAIT_CORE,
    TX_WAIT,
    TX_GO
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] hold_reg, hold_next;
  logic       pending_reg, pending_next;
  logic [9:0] addr_reg, addr_next;
  logic [6:0] byte_reg, byte_next;
  logic       overrun_reg, overrun_next;
  logic [3:0] digit_reg, digit_next;
  logic [7:0] tx_data_reg, tx_data_next;

  logic last_bit;
  logic last_byte;

  // The bit index within the current byte is the low three address bits.
  assign last_bit  = (addr_reg[2:0] == 3'd7);
  assign last_byte = (byte_reg == 7'd97);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    hold_next    = hold_reg;
    pending_next = pending_reg;
    addr_next    = addr_reg;
    byte_next    = byte_reg;
    overrun_next = overrun_reg;
    digit_next   = digit_reg;
    tx_data_next = tx_data_reg;

    unique case (state_reg)
      IDLE: begin
        if (bus.rx_rdy) begin
          shift_next = bus.rx_data;
          state_next = WRITE;
        end
      end
      WRITE: begin
        shift_next = shift_reg >> 1;
        if (!last_bit) begin
          addr_next = addr_reg + 10'd1;
          // The image is complete once byte 97 is being written, so any
          // further byte has nowhere to go.
          if (bus.rx_rdy) begin
            if (pending_reg || last_byte) begin
              overrun_next = 1'b1;
            end else begin
              hold_next    = bus.rx_data;
              pending_next = 1'b1;
            end
          end
        end else if (last_byte) begin
          state_next = START;
          if (bus.rx_rdy) begin
            overrun_next = 1'b1;
          end
        end else begin
          addr_next = addr_reg + 10'd1;
          byte_next = byte_reg + 7'd1;
          if (pending_reg) begin
            shift_next   = hold_reg;
            pending_next = 1'b0;
            if (bus.rx_rdy) begin
              overrun_next = 1'b1;
            end
          end else if (bus.rx_rdy) begin
            // A byte arriving on the final bit chains straight into WRITE.
            shift_next = bus.rx_data;
          end else begin
            state_next = IDLE;
          end
        end
      end
      START: begin
        state_next = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (bus.core_done) begin
          digit_next   = bus.core_digit;
          tx_data_next = (bus.core_digit <= 4'd9) ? (8'h30 + {4'd0, bus.core_digit})
                                                  : 8'h3F;
          state_next   = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (bus.tx_rdy) begin
          state_next = TX_GO;
        end
      end
      TX_GO: begin
        addr_next  = 10'd0;
        byte_next  = 7'd0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (bus.rx_rdy && (state_reg inside {START, WAIT_CORE, TX_WAIT, TX_GO})) begin
      overrun_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg   <= 8'd0;
      hold_reg    <= 8'd0;
      pending_reg <= 1'b0;
      addr_reg    <= 10'd0;
      byte_reg    <= 7'd0;
      overrun_reg <= 1'b0;
      digit_reg   <= 4'd0;
      tx_data_reg <= 8'h30;
    end else begin
      shift_reg   <= shift_next;
      hold_reg    <= hold_next;
      pending_reg <= pending_next;
      addr_reg    <= addr_next;
      byte_reg    <= byte_next;
      overrun_reg <= overrun_next;
      digit_reg   <= digit_next;
      tx_data_reg <= tx_data_next;
    end
  end

  assign bus.ram_we     = (state_reg == WRITE);
  assign bus.ram_d      = (state_reg == WRITE) && shift_reg[0];
  assign bus.ram_addr   = addr_reg;
  assign bus.core_start = (state_reg == START);
  assign bus.tx_start   = (state_reg == TX_GO);
  assign bus.tx_data    = tx_data_reg;
  assign bus.digit_out  = digit_reg;
  assign bus.overrun    = overrun_reg;

endmodule

// File: doc/snn_seq_ctrl.md
SNN_SEQ_CTRL -- requirements
Module: snn_seq_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state changes on posedge clk.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset; sampled on posedge clk only.
REQ-003 SHALL have port: rx_rdy  input  1  one-cycle strobe, received UART byte valid on rx_data.
REQ-004 SHALL have port: rx_data  input  8  received image byte, 8 pixels, bit 0 first.
REQ-005 SHALL have port: ram_we  output  1  write enable to input-unit RAM.
REQ-006 SHALL have port: ram_addr  output  10  input-unit RAM address, 0..783.
REQ-007 SHALL have port: ram_d  output  1  pixel bit written to input-unit RAM.
REQ-008 SHALL have port: core_start  output  1  one-cycle start pulse to inference core.
REQ-009 SHALL have port: core_done  input  1  inference core completion strobe.
REQ-010 SHALL have port: core_digit  input  4  inference result, valid in the core_done cycle.
REQ-011 SHALL have port: tx_rdy  input  1  UART transmitter idle.
REQ-012 SHALL have port: tx_start  output  1  one-cycle transmit request.
REQ-013 SHALL have port: tx_data  output  8  ASCII result byte.
REQ-014 SHALL have port: digit_out  output  4  last latched result.
REQ-015 SHALL have port: overrun  output  1  sticky flag, image byte lost.

Function
REQ-016 SHALL implement states IDLE, WRITE, START, WAIT_CORE, TX_WAIT, TX_GO.
REQ-017 SHALL, in IDLE on rx_rdy, latch rx_data into an 8-bit shift register and enter WRITE next cycle.
REQ-018 SHALL, in WRITE, assert ram_we for exactly 8 consecutive cycles with ram_d = shift[0], shifting right each cycle.
REQ-019 SHALL write bit i of byte k (k = 0..97) to ram_addr = 8k+i; ram_addr increments by 1 per WRITE cycle.
REQ-020 SHALL keep a 7-bit byte counter; after the 8th bit of bytes 0..96, return to IDLE; after the 8th bit of byte 97 (addr 783), enter START.
REQ-021 SHALL provide a one-byte holding register: rx_rdy during WRITE stores rx_data and sets pending; on WRITE exit, if pending, load shift register from it, clear pending, re-enter WRITE with no IDLE cycle.
REQ-022 SHALL set overrun when rx_rdy arrives while pending is already set (byte discarded), or in START, WAIT_CORE, TX_WAIT, TX_GO (byte discarded); overrun clears only on rst.
REQ-023 SHALL, in START, assert core_start for exactly one cycle and enter WAIT_CORE; ram_we = 0 outside WRITE.
REQ-024 SHALL, in WAIT_CORE, on core_done latch core_digit into digit_out and enter TX_WAIT; core_done in any other state is ignored.
REQ-025 SHALL, in TX_WAIT, stay until tx_rdy = 1, then enter TX_GO.
REQ-026 SHALL, in TX_GO, assert tx_start for one cycle, then enter IDLE with ram_addr = 0 and byte counter = 0.
REQ-027 SHALL drive tx_data = 8'h30 + digit_out when digit_out <= 9, else 8'h3F ('?'); tx_data held stable from TX_WAIT through TX_GO.
REQ-028 SHALL yield latency from rx_rdy of byte 97 (accepted in IDLE) to core_start = 9 cycles (1 latch + 8 WRITE).
REQ-029 SHALL ignore rx_data when rx_rdy = 0.

Reset
REQ-030 SHALL, on rst = 1 at posedge clk, from any state (including mid-WRITE), enter IDLE and set ram_we = 0, ram_addr = 0, ram_d = 0, core_start = 0, tx_start = 0, tx_data = 8'h30, digit_out = 0, overrun = 0, pending = 0, byte counter = 0.
REQ-031 SHALL, after rst mid-image, treat the next rx_rdy byte as byte 0 (addr 0).

Verification
REQ-032 SHALL pass: one byte 8'hA5 in IDLE -> ram_we high 8 cycles, addrs 0..7, ram_d = 1,0,1,0,0,1,0,1; then IDLE.
REQ-033 SHALL pass: 98 bytes spaced 20 cycles -> exactly 784 writes addr 0..783, single core_start 9 cycles after last rx_rdy, no overrun.
REQ-034 SHALL pass: core_done with core_digit = 7, tx_rdy = 0 for 5 cycles then 1 -> tx_start one cycle after tx_rdy rises, tx_data = 8'h37, digit_out = 7.
REQ-035 SHALL pass: core_digit = 12 -> tx_data = 8'h3F; two rx_rdy during one WRITE -> first byte written back-to-back at next 8 addrs, second discarded, overrun = 1.
REQ-036 SHALL pass: rst asserted at 4th WRITE cycle of byte 10 -> ram_we = 0 next cycle, following byte written at addr 0..7, overrun = 0.
